// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the issuing pipeline and the iterative multiply/divide unit.
interface muldiv_unit_if #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 5
);
    logic                     start;
    logic [1:0]               op;
    logic [DATA_WIDTH-1:0]    operand_a;
    logic [DATA_WIDTH-1:0]    operand_b;
    logic [ADDRESS_WIDTH-1:0] dest_addr;
    logic                     busy;
    logic                     done;
    logic [DATA_WIDTH-1:0]    result;
    logic [ADDRESS_WIDTH-1:0] result_addr;
    logic                     regwrite_en;

    modport master (
        output start, op, operand_a, operand_b, dest_addr,
        input  busy, done, result, result_addr, regwrite_en
    );

    modport slave (
        input  start, op, operand_a, operand_b, dest_addr,
        output busy, done, result, result_addr, regwrite_en
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle.
// Define MULDIV_DIV_EN to include the divide datapath; otherwise DIVU/REMU complete early with result 0.
module muldiv_unit #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 5
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]    hi_q, hi_d;
    logic [DATA_WIDTH-1:0]    lo_q, lo_d;
    logic [DATA_WIDTH-1:0]    m_q, m_d;
    logic [1:0]               op_q, op_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    result_q, result_d;
    logic [ADDRESS_WIDTH-1:0] result_addr_q, result_addr_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     wen_q, wen_d;
    logic [DATA_WIDTH:0]      add_sum;
`ifdef MULDIV_DIV_EN
    logic [DATA_WIDTH:0]      trial;
    logic [DATA_WIDTH:0]      diff;
`endif

    // Multiply keeps {hi,lo} as the partial product with the multiplier shifting out of lo;
    // divide keeps the partial remainder in hi and shifts quotient bits into lo.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        m_d           = m_q;
        op_d          = op_q;
        addr_d        = addr_q;
        result_d      = result_q;
        result_addr_d = result_addr_q;
        wen_d         = 1'b0;
        add_sum       = {1'b0, hi_q} + {1'b0, m_q};
`ifdef MULDIV_DIV_EN
        trial         = {hi_q, lo_q[DATA_WIDTH-1]};
        diff          = trial - {1'b0, m_q};
`endif

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    op_d    = bus.op;
                    addr_d  = bus.dest_addr;
                    cnt_d   = '0;
                    hi_d    = '0;
                    if (bus.op[1]) begin
                        lo_d = bus.operand_a;
                        m_d  = bus.operand_b;
`ifndef MULDIV_DIV_EN
                        cnt_d = CNT_W'(DATA_WIDTH);
`endif
                    end else begin
                        lo_d = bus.operand_b;
                        m_d  = bus.operand_a;
                    end
                end
            end
            RUN: begin
                if (cnt_q == CNT_W'(DATA_WIDTH)) begin
                    state_d       = DONE;
                    result_addr_d = addr_q;
                    wen_d         = (addr_q != '0);
                    case (op_q)
                        2'b00:   result_d = lo_q;
                        2'b01:   result_d = hi_q;
                        2'b10:   result_d = lo_q;
                        default: result_d = hi_q;
                    endcase
`ifndef MULDIV_DIV_EN
                    if (op_q[1]) begin
                        result_d = '0;
                        wen_d    = 1'b0;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (op_q[1]) begin
`ifdef MULDIV_DIV_EN
                        // b == 0 always passes the compare: quotient all-ones, remainder = dividend
                        if (trial >= {1'b0, m_q}) begin
                            hi_d = diff[DATA_WIDTH-1:0];
                            lo_d = {lo_q[DATA_WIDTH-2:0], 1'b1};
                        end else begin
                            hi_d = trial[DATA_WIDTH-1:0];
                            lo_d = {lo_q[DATA_WIDTH-2:0], 1'b0};
                        end
`endif
                    end else if (lo_q[0]) begin
                        {hi_d, lo_d} = {add_sum, lo_q[DATA_WIDTH-1:1]};
                    end else begin
                        {hi_d, lo_d} = {1'b0, hi_q, lo_q[DATA_WIDTH-1:1]};
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            m_q           <= '0;
            op_q          <= '0;
            addr_q        <= '0;
            result_q      <= '0;
            result_addr_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            wen_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            m_q           <= m_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            result_q      <= result_d;
            result_addr_q <= result_addr_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            wen_q         <= wen_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.result_addr = result_addr_q;
    assign bus.regwrite_en = wen_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, busy/reset sequences, random ops vs arithmetic model.
module tb_muldiv_unit;
    localparam int unsigned W  = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned W2 = 2 * W;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic clk;
    logic reset;
    int   total;
    int   bad;

    muldiv_unit_if #(.DATA_WIDTH(W), .ADDRESS_WIDTH(AW)) bus ();
    muldiv_unit #(.DATA_WIDTH(W), .ADDRESS_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [AW-1:0] dest;
        logic [W-1:0]  exp;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W2-1:0] p;
        p = W2'(a) * W2'(b);
        if (op[1] && !DIV_ON) return '0;
        case (op)
            2'd0:    return p[W-1:0];
            2'd1:    return p[W2-1:W];
            2'd2:    return (b == '0) ? '1 : a / b;
            default: return (b == '0) ? a : a % b;
        endcase
    endfunction

    // Issues one op, optionally keeps start asserted (with other operands) through RUN and DONE.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [AW-1:0] dest, input logic [W-1:0] exp, input bit pester);
        int   n;
        bit   seen;
        int   exp_lat;
        logic exp_wen;
        exp_lat = (!DIV_ON && op[1]) ? 2 : int'(W) + 2;
        exp_wen = (dest != '0) && (DIV_ON || !op[1]);
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.op        = op;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.dest_addr = dest;
        @(posedge clk); #1;
        n = 1;
        bus.start     = pester;
        bus.op        = ~op;
        bus.operand_a = $urandom;
        bus.operand_b = $urandom;
        bus.dest_addr = ~dest;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            check("busy_during_run", 64'(bus.busy), 64'(1));
            check("wen_low_during_run", 64'(bus.regwrite_en), 64'(0));
            @(posedge clk);
            n++;
        end
        check("done_seen", 64'(seen), 64'(1));
        check("latency", 64'(n), 64'(exp_lat));
        check("result", 64'(bus.result), 64'(exp));
        check("result_addr", 64'(bus.result_addr), 64'(dest));
        check("regwrite_en", 64'(bus.regwrite_en), 64'(exp_wen));
        check("busy_in_done", 64'(bus.busy), 64'(1));
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("done_pulse_end", 64'(bus.done), 64'(0));
        check("wen_pulse_end", 64'(bus.regwrite_en), 64'(0));
        check("idle_after_done", 64'(bus.busy), 64'(0));
        check("result_hold", 64'(bus.result), 64'(exp));
    endtask

    initial begin
        int            spurious;
        logic [1:0]    rop;
        logic [W-1:0]  ra;
        logic [W-1:0]  rb;
        logic [AW-1:0] rd;

        total = 0;
        bad   = 0;
        vecs[0]  = '{2'd0, 32'h0000_0007, 32'h0000_0006, 5'd3,  32'h0000_002A};
        vecs[1]  = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE};
        vecs[2]  = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'h0000_0001};
        vecs[3]  = '{2'd2, 32'd100,       32'd7,         5'd6,  DIV_ON ? 32'd14 : 32'd0};
        vecs[4]  = '{2'd3, 32'd100,       32'd7,         5'd7,  DIV_ON ? 32'd2 : 32'd0};
        vecs[5]  = '{2'd2, 32'h1234_5678, 32'd0,         5'd8,  DIV_ON ? 32'hFFFF_FFFF : 32'd0};
        vecs[6]  = '{2'd3, 32'h1234_5678, 32'd0,         5'd9,  DIV_ON ? 32'h1234_5678 : 32'd0};
        vecs[7]  = '{2'd0, 32'd5,         32'd5,         5'd0,  32'd25};
        vecs[8]  = '{2'd1, 32'h8000_0000, 32'd2,         5'd31, 32'd1};
        vecs[9]  = '{2'd2, 32'd5,         32'd9,         5'd1,  32'd0};
        vecs[10] = '{2'd3, 32'd5,         32'd9,         5'd2,  DIV_ON ? 32'd5 : 32'd0};

        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.op        = '0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.dest_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 64'(bus.busy), 64'(0));
        check("reset_done", 64'(bus.done), 64'(0));
        check("reset_wen", 64'(bus.regwrite_en), 64'(0));
        check("reset_result", 64'(bus.result), 64'(0));
        check("reset_result_addr", 64'(bus.result_addr), 64'(0));
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 11; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest, vecs[i].exp, 1'b0);

        // start held through RUN and DONE with different operands must not disturb or re-trigger
        run_op(2'd0, 32'd1234, 32'd5, 5'd11, 32'd6170, 1'b1);

        // reset at iteration 10 aborts with no done pulse
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.op        = 2'd0;
        bus.operand_a = 32'd77;
        bus.operand_b = 32'd3;
        bus.dest_addr = 5'd12;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_done", 64'(bus.done), 64'(0));
        check("abort_wen", 64'(bus.regwrite_en), 64'(0));
        check("abort_result", 64'(bus.result), 64'(0));
        check("abort_result_addr", 64'(bus.result_addr), 64'(0));
        spurious = 0;
        for (int i = 0; i < int'(W) + 5; i++) begin
            @(negedge clk);
            if (bus.done || bus.regwrite_en) spurious++;
        end
        check("abort_no_done", 64'(spurious), 64'(0));

        // reset wins over a simultaneous start
        @(posedge clk); #1;
        reset     = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("reset_over_start", 64'(bus.busy), 64'(0));

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = '0;
                1, 2:    rb = W'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            rd = AW'($urandom_range(0, 31));
            run_op(rop, ra, rb, rd, model(rop, ra, rb), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
